soc_sysinfo: RTL and testbench
==============================

SOC_SYSINFO -- requirements
Module: soc_sysinfo

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h0000_1000, 32-bit system ID returned at word 0.
REQ-002 SHALL have parameter TIMESTAMP, default 32'h0000_0000, 32-bit build timestamp returned at word 1.
REQ-003 SHALL have parameter NUM_SCRATCH, default 2, legal range 1..4, the number of read/write scratch words.
REQ-004 SHALL have port clock, input, 1, the single clock; all state SHALL be clocked on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port address, input, 4, the word address.
REQ-007 SHALL have port read, input, 1, the read strobe.
REQ-008 SHALL have port write, input, 1, the write strobe.
REQ-009 SHALL have port writedata, input, 32, the write data.
REQ-010 SHALL have port readdata, output, 32, the registered read data.
REQ-011 SHALL have port readdatavalid, output, 1, a one-cycle pulse qualifying readdata.

Function
REQ-012 Register map (word address) SHALL be as follows.
- 0: ID, read-only.
- 1: TIMESTAMP, read-only.
- 2: UPTIME_LO, read-only.
- 3: UPTIME_HI, read-only shadow.
- 4: CTRL.
- 5: STATUS.
- 6 .. 5+NUM_SCRATCH: SCRATCH[n], read/write.
REQ-013 Unmapped addresses SHALL read 0, and writes to them SHALL be ignored.
REQ-014 Writes to read-only words SHALL be ignored.
REQ-015 Read latency SHALL be fixed at 1.
- A read at edge N SHALL give readdatavalid=1 and readdata valid after edge N+1.
- readdatavalid SHALL be 1 for exactly one cycle per read.
- Back-to-back reads SHALL be accepted every cycle.
REQ-016 readdata SHALL hold its last value while readdatavalid=0.
REQ-017 When read and write hit the same word in the same cycle, readdata SHALL return the pre-write value, and the write SHALL take effect.
REQ-018 The uptime counter SHALL be 64 bits and increment by 1 each clock unless frozen or cleared.
REQ-019 A read of UPTIME_LO SHALL return the current low 32 bits and, in the same edge, copy the current high 32 bits into the UPTIME_HI shadow.
REQ-020 A read of UPTIME_HI SHALL return the shadow, never the live value.
REQ-021 CTRL bit0 (CLEAR) SHALL be write-1-pulse.
- It SHALL zero the counter on the next edge.
- It SHALL read back as 0.
REQ-022 CTRL bit1 (FREEZE) SHALL be read/write.
- When 1, the counter SHALL hold.
- Other CTRL bits SHALL read 0.
REQ-023 When CLEAR and FREEZE are both asserted, clear SHALL win: the counter becomes 0 and then holds.
REQ-024 On a wrap from all-ones to 0, STATUS bit0 (OVF) SHALL set and stay set.
REQ-025 Writing 1 to STATUS bit0 SHALL clear OVF; writing 0 SHALL have no effect.
REQ-026 When wrap and W1C occur in the same cycle, set SHALL win.
REQ-027 A CLEAR in the wrap cycle SHALL suppress OVF set.

Reset
REQ-028 Asserting reset_n=0 SHALL immediately clear the following:
- readdata=0 and readdatavalid=0.
- The counter, the shadow, CTRL and OVF.
- All SCRATCH words.
REQ-029 Reset mid-read SHALL drop the pending readdatavalid.
REQ-030 Deassertion SHALL take effect at the first rising edge with reset_n=1.

Configuration
REQ-031 Macro SOC_SYSINFO_UPTIME_EN SHALL compile the uptime feature in or out.
- Defined: the counter, shadow, CTRL and STATUS SHALL behave per REQ-018..027.
- Undefined: no counter or shadow logic SHALL exist; words 2-5 SHALL read 0 and ignore writes; ID, TIMESTAMP and SCRATCH SHALL be unchanged.

Verification
REQ-032 Reset, then read address 0 with the defaults -> readdatavalid one cycle later with readdata=32'h0000_1000; address 1 -> 0.
REQ-033 Write 32'hDEAD_BEEF to 6, write 32'h1234_5678 to 7, then read 6, 7, 9 back-to-back -> three consecutive valid cycles returning DEAD_BEEF, 12345678, 0.
REQ-034 Force the counter to 64'h0000_0000_FFFF_FFFE, read 2 at that edge, then read 3 -> LO=FFFF_FFFE, HI=0, even though the live high word becomes 1 two cycles later.
REQ-035 Write CTRL=2'b11 -> counter reads 0 and stays 0 over 10 cycles; then write CTRL=0 -> counter reads increase by 1 per cycle.
REQ-036 Counter at 64'hFFFF_FFFF_FFFF_FFFF -> STATUS reads 1 after the wrap; write STATUS=1 -> reads 0; wrap coinciding with W1C -> reads 1.
REQ-037 Assert reset_n=0 mid-read with SCRATCH0=5 -> readdatavalid stays 0 and SCRATCH0 reads 0 after release; build without SOC_SYSINFO_UPTIME_EN -> words 2..5 read 0.

Source files
------------

// File: rtl/soc_sysinfo.sv
// System information block: ID, build timestamp, scratch words and an optional
// 64-bit uptime counter with OVF status, compiled in by SOC_SYSINFO_UPTIME_EN.
module soc_sysinfo #(
    parameter logic [31:0] ID_VALUE    = 32'h0000_1000,
    parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
    parameter int unsigned NUM_SCRATCH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    localparam logic [3:0] ADDR_ID     = 4'd0;
    localparam logic [3:0] ADDR_TS     = 4'd1;
    localparam logic [3:0] ADDR_UP_LO  = 4'd2;
    localparam logic [3:0] ADDR_UP_HI  = 4'd3;
    localparam logic [3:0] ADDR_CTRL   = 4'd4;
    localparam logic [3:0] ADDR_STATUS = 4'd5;
    localparam int unsigned SCRATCH_BASE = 6;

    logic [31:0] scratch [NUM_SCRATCH];
    logic [31:0] rd_word;

`ifdef SOC_SYSINFO_UPTIME_EN
    logic [63:0] uptime;
    logic [31:0] uptime_hi_shadow;
    logic        freeze;
    logic        ovf;
    logic        clear_hit;
    logic        wrap;
    logic        ovf_w1c;

    assign clear_hit = write && (address == ADDR_CTRL) && writedata[0];
    // Wrap only counts when the counter actually advances; a clear suppresses it.
    assign wrap      = !freeze && !clear_hit && (uptime == '1);
    assign ovf_w1c   = write && (address == ADDR_STATUS) && writedata[0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime           <= '0;
            uptime_hi_shadow <= '0;
            freeze           <= 1'b0;
            ovf              <= 1'b0;
        end else begin
            if (clear_hit) begin
                uptime <= '0;
            end else if (!freeze) begin
                uptime <= uptime + 64'd1;
            end
            if (write && (address == ADDR_CTRL)) begin
                freeze <= writedata[1];
            end
            if (read && (address == ADDR_UP_LO)) begin
                uptime_hi_shadow <= uptime[63:32];
            end
            if (wrap) begin
                ovf <= 1'b1;
            end else if (ovf_w1c) begin
                ovf <= 1'b0;
            end
        end
    end
`endif

    // Mux reads pre-edge state, so a same-cycle write is not visible in the read.
    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_ID:     rd_word = ID_VALUE;
            ADDR_TS:     rd_word = TIMESTAMP;
`ifdef SOC_SYSINFO_UPTIME_EN
            ADDR_UP_LO:  rd_word = uptime[31:0];
            ADDR_UP_HI:  rd_word = uptime_hi_shadow;
            ADDR_CTRL:   rd_word = {30'd0, freeze, 1'b0};
            ADDR_STATUS: rd_word = {31'd0, ovf};
`endif
            default: begin
                for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                    if (address == 4'(SCRATCH_BASE + i)) begin
                        rd_word = scratch[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                scratch[i] <= '0;
            end
        end else if (write) begin
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                if (address == 4'(SCRATCH_BASE + i)) begin
                    scratch[i] <= writedata;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_soc_sysinfo.sv
// Bench for soc_sysinfo: table vectors, hand-written corner sequences and a
// randomized run checked against a register-map model.
module tb_soc_sysinfo;

    localparam int unsigned NS = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;

    int vectors = 0;
    int miscompares = 0;

    soc_sysinfo dut (
        .clock(clock),
        .reset_n(reset_n),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
        .readdata(readdata),
        .readdatavalid(readdatavalid)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [31:0] m_scratch [NS];
    logic [31:0] m_last;
    logic [63:0] m_up;
    logic [31:0] m_shadow;
    logic        m_freeze;
    logic        m_ovf;

    logic        exp_valid;
    logic [31:0] exp_data;
    logic        got_valid;
    logic [31:0] got_data;

    typedef struct {
        logic [3:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) m_scratch[i] = '0;
        m_last   = '0;
        m_up     = '0;
        m_shadow = '0;
        m_freeze = 1'b0;
        m_ovf    = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] v;
        v = '0;
        if (a == 0) v = 32'h0000_1000;
        else if (a == 1) v = 32'h0000_0000;
`ifdef SOC_SYSINFO_UPTIME_EN
        else if (a == 2) v = m_up[31:0];
        else if (a == 3) v = m_shadow;
        else if (a == 4) v = {30'd0, m_freeze, 1'b0};
        else if (a == 5) v = {31'd0, m_ovf};
`endif
        else if (a >= 6 && a < 6 + NS) v = m_scratch[a - 6];
        return v;
    endfunction

    // One clock: drive at negedge, model the edge, sample at next negedge.
    task automatic step(input int a, input logic r, input logic w, input logic [31:0] wd);
        logic clr;
        logic wrapped;
        address   = 4'(a);
        read      = r;
        write     = w;
        writedata = wd;
        @(posedge clock);
        exp_valid = r;
        exp_data  = r ? model_read(a) : m_last;
        if (w && a >= 6 && a < 6 + NS) m_scratch[a - 6] = wd;
`ifdef SOC_SYSINFO_UPTIME_EN
        clr = w && (a == 4) && wd[0];
        wrapped = 1'b0;
        if (r && a == 2) m_shadow = m_up[63:32];
        if (clr) m_up = '0;
        else if (!m_freeze) begin
            wrapped = (m_up == 64'hFFFF_FFFF_FFFF_FFFF);
            m_up = m_up + 64'd1;
        end
        if (wrapped) m_ovf = 1'b1;
        else if (w && a == 5 && wd[0]) m_ovf = 1'b0;
        if (w && a == 4) m_freeze = wd[1];
`else
        clr = 1'b0;
        wrapped = clr;
`endif
        m_last = exp_data;
        @(negedge clock);
        got_valid = readdatavalid;
        got_data  = readdata;
    endtask

    task automatic step_chk(input string name, input int a, input logic r, input logic w,
                            input logic [31:0] wd);
        step(a, r, w, wd);
        chk({name, "_valid"}, {31'd0, got_valid}, {31'd0, exp_valid});
        chk({name, "_data"}, got_data, exp_data);
    endtask

`ifdef SOC_SYSINFO_UPTIME_EN
    task automatic force_counter(input logic [63:0] v);
        dut.uptime = v;
        m_up = v;
    endtask
`endif

    initial begin
        reset_n   = 1'b1;
        address   = '0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = '0;
        model_reset();
        #1 reset_n = 1'b0;
        #1;
        chk("reset_valid", {31'd0, readdatavalid}, 32'd0);
        chk("reset_data", readdata, 32'd0);
        @(negedge clock);
        read = 1'b1;
        @(negedge clock);
        chk("reset_hold_valid", {31'd0, readdatavalid}, 32'd0);
        read = 1'b0;
        reset_n = 1'b1;

        tbl.push_back('{4'd0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_1000});
        tbl.push_back('{4'd1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0000});
        tbl.push_back('{4'd6, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000});
        tbl.push_back('{4'd7, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0000_0000});
        tbl.push_back('{4'd6, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF});
        tbl.push_back('{4'd7, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_5678});
        tbl.push_back('{4'd9, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0000});
        tbl.push_back('{4'd7, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_5678});
        tbl.push_back('{4'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h1234_5678});
        tbl.push_back('{4'd6, 1'b1, 1'b1, 32'hA5A5_A5A5, 1'b1, 32'hDEAD_BEEF});
        tbl.push_back('{4'd6, 1'b1, 1'b0, 32'h0, 1'b1, 32'hA5A5_A5A5});
        tbl.push_back('{4'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hA5A5_A5A5});
        tbl.push_back('{4'd0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_1000});
        tbl.push_back('{4'd1, 1'b0, 1'b1, 32'h7777_7777, 1'b0, 32'h0000_1000});
        tbl.push_back('{4'd1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0000});
        tbl.push_back('{4'd8, 1'b0, 1'b1, 32'h5555_AAAA, 1'b0, 32'h0000_0000});
        tbl.push_back('{4'd8, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0000});
        tbl.push_back('{4'd15, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0000});
`ifndef SOC_SYSINFO_UPTIME_EN
        for (int a = 2; a <= 5; a++) begin
            tbl.push_back('{4'(a), 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000});
            tbl.push_back('{4'(a), 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0000});
        end
`endif
        foreach (tbl[i]) begin
            step(int'(tbl[i].addr), tbl[i].rd, tbl[i].wr, tbl[i].wdata);
            chk($sformatf("tbl%0d_valid", i), {31'd0, got_valid}, {31'd0, tbl[i].exp_valid});
            chk($sformatf("tbl%0d_data", i), got_data, tbl[i].exp_data);
        end

`ifdef SOC_SYSINFO_UPTIME_EN
        // Shadow captures the high word at the LO read edge
        force_counter(64'h0000_0000_FFFF_FFFE);
        step(2, 1'b1, 1'b0, 32'h0);
        chk("shadow_lo", got_data, 32'hFFFF_FFFE);
        step(3, 1'b1, 1'b0, 32'h0);
        chk("shadow_hi", got_data, 32'h0000_0000);
        step_chk("shadow_hi_model", 3, 1'b1, 1'b0, 32'h0);

        step(4, 1'b0, 1'b1, 32'h3);
        for (int k = 0; k < 10; k++) begin
            step(2, 1'b1, 1'b0, 32'h0);
            chk("frozen", got_data, 32'h0);
        end
        step(4, 1'b1, 1'b0, 32'h0);
        chk("ctrl_read", got_data, 32'h2);
        step(4, 1'b0, 1'b1, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(2, 1'b1, 1'b0, 32'h0);
            chk("incr", got_data, 32'(k));
        end

        force_counter(64'hFFFF_FFFF_FFFF_FFFF);
        step(0, 1'b0, 1'b0, 32'h0);
        step(5, 1'b1, 1'b0, 32'h0);
        chk("ovf_set", got_data, 32'h1);
        step(5, 1'b0, 1'b1, 32'h0);
        step(5, 1'b1, 1'b0, 32'h0);
        chk("ovf_w0", got_data, 32'h1);
        step(5, 1'b0, 1'b1, 32'h1);
        step(5, 1'b1, 1'b0, 32'h0);
        chk("ovf_w1c", got_data, 32'h0);
        force_counter(64'hFFFF_FFFF_FFFF_FFFF);
        step(5, 1'b0, 1'b1, 32'h1);
        step(5, 1'b1, 1'b0, 32'h0);
        chk("ovf_set_wins", got_data, 32'h1);
        step(5, 1'b0, 1'b1, 32'h1);
        force_counter(64'hFFFF_FFFF_FFFF_FFFF);
        step(4, 1'b0, 1'b1, 32'h1);
        step(5, 1'b1, 1'b0, 32'h0);
        chk("ovf_clear_suppress", got_data, 32'h0);
        step_chk("up_after_clear", 2, 1'b1, 1'b0, 32'h0);
`endif

        // Reset mid-read drops the pending valid and clears scratch
        step(6, 1'b0, 1'b1, 32'h5);
        step(6, 1'b1, 1'b0, 32'h0);
        chk("scratch0_pre", got_data, 32'h5);
        address = 4'd6;
        read    = 1'b1;
        write   = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("midread_valid", {31'd0, readdatavalid}, 32'd0);
        chk("midread_data", readdata, 32'd0);
        @(negedge clock);
        chk("midread_hold", {31'd0, readdatavalid}, 32'd0);
        read = 1'b0;
        reset_n = 1'b1;
        model_reset();
        step(6, 1'b1, 1'b0, 32'h0);
        chk("scratch0_post", got_data, 32'h0);
        chk("scratch0_post_valid", {31'd0, got_valid}, 32'd1);

        for (int n = 0; n < 400; n++) begin
            int a;
            logic r;
            logic w;
            a = int'($urandom_range(0, 15));
            r = 1'($urandom_range(0, 1));
            w = ($urandom_range(0, 3) == 0);
            step_chk("rand", a, r, w, $urandom);
        end

        read  = 1'b0;
        write = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
